seq_alu: RTL
============

# seq_alu

Parametrised, registered ALU for the TinyFPGA CPU datapath. It extends the single-cycle add/logic/shift/load operation set with iterative unsigned multiply and divide, a start/busy/done handshake, and registered flags, including a new signed-overflow flag. It sits between the register file read ports and the writeback mux. The sequencer stalls on `busy` and writes back on `done`.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; must be even and ≥ 8.
- `MULDIV_EN`, 1: when 0, class-3 operations behave as illegal ops; the multi-cycle logic is not built.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only when `busy`=0.
- `opClass` in 2: 0 ALU, 1 SHIFT, 2 LOAD, 3 MULDIV.
- `operation` in 3: opcode within the class.
- `operand1`, `operand2` in WIDTH: operands, sampled when `start` is accepted.
- `carryIn` in 1: carry flag from the status register.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; results are valid from this cycle onward.
- `result` out WIDTH: main result (MUL low word, DIV quotient).
- `resultHigh` out WIDTH: MUL high word or DIV remainder; 0 for all other ops.
- `carryOut`, `zeroOut`, `negativeOut`, `overflowOut` out 1: registered flags.

## Operation
**ALU class:** ADD 0, ADC 1, SUB 2, SBC 3, AND 4, OR 5, XOR 6, NOT 7 (NOT is ~operand1).
- Arithmetic is computed at WIDTH+1 bits; `carryOut` is the MSB.
- For SUB/SBC, `carryOut`=1 means borrow.
- Logic ops pass `carryIn` through to `carryOut`.

**SHIFT class:** SHR 0, SHL 1, ASHR 2, ROR 3, ROL 4.
- Shift amount is 1. The shifted-out bit goes to `carryOut`; ROR/ROL rotate through carry.
- Opcodes 5–7 are illegal.

**LOAD class:** H = WIDTH/2.
- COPY 0: operand1.
- LDL 1: zero-extended low half of operand1.
- LDH 2: high half of operand1 moved to the low half, zero-extended.
- SWAP 3: exchange the two halves of operand1.
- LDLI 4: {operand2 high half, operand1 low half}.
- LDHI 5: {operand1 high half, operand2 low half}.
- LDLZI 6: {0, operand1 low half}.
- LDHZI 7: {operand1 high half, 0}.
- `carryOut` = `carryIn`.

**MULDIV class:** MULU 0, DIVU 1; opcodes 2–7 are illegal.
- MULU: shift-add, one bit per cycle, WIDTH iterations. Output is {resultHigh, result} = operand1 × operand2.
- DIVU: restoring division, WIDTH iterations. `result` = quotient, `resultHigh` = remainder.
- DIVU with operand2 = 0 is single-cycle: `result` = all ones, `resultHigh` = operand1, `overflowOut` = 1.

**Flags:**
- `zeroOut`: `result`==0. For MULU, {resultHigh, result}==0.
- `negativeOut`: MSB of `result`; MSB of `resultHigh` for MULU.
- `overflowOut`:
  - ADD/ADC/SUB/SBC: signed overflow.
  - MULU: `resultHigh`≠0.
  - DIVU: divide by zero.
  - All other ops: 0.
- `carryOut` = `carryIn` for MULDIV.

**Illegal op:** single-cycle; `result` = operand1, `resultHigh` = 0, `carryOut` = `carryIn`, `overflowOut` = 0.

**State machine:** IDLE, MUL, DIV.
- IDLE + accepted MULU → MUL; DIVU with nonzero divisor → DIV; all other ops stay in IDLE.
- MUL/DIV → IDLE when the iteration counter (width clog2(WIDTH)+1) reaches WIDTH.
- `start` while `busy`=1 is ignored: no queueing, no error.
- Outputs hold their last value between operations.

## Timing
- **Reset:** all outputs 0 (`result`, `resultHigh`, every flag, `busy`, `done`); state IDLE; counter 0.
- **Reset mid-operation:** aborts immediately; no `done` pulse is issued.
- **Single-cycle ops:** `start` accepted in cycle T → outputs and flags updated, `done`=1 in T+1.
- **MULU/DIVU:** `busy`=1 in T+1..T+WIDTH. In T+WIDTH+1, `done`=1 and `busy`=0.
- **Back-to-back:** a new `start` may be presented in the `done` cycle and is accepted there.
- **Intermediate values:** `result`/`resultHigh` are not updated during iteration; only the final values appear, at `done`.
- Operands may change after acceptance without effect.

## Structure
- **Package `alu_pkg`:** opClass and opcode localparams for all four classes; state enum {IDLE, MUL, DIV}; helper function for signed overflow.
- **Sub-module `alu_core`:** purely combinational ALU/SHIFT/LOAD datapath (WIDTH-parametrised) returning {carry, result, overflow}.
- **In `seq_alu`:** FSM, operand/accumulator registers, iteration counter, flag registers, and the handshake.

## Test plan
All values for WIDTH=16, start accepted in cycle T.
1. ADD 0x7FFF + 0x0001 → T+1: `done` pulse; result 0x8000, carry 0, negative 1, overflow 1, zero 0.
2. SUB 0x0000 − 0x0001 → result 0xFFFF, carry 1, negative 1, overflow 0. Then ROR 0x0001 with carryIn=1 → result 0x8000, carry 1.
3. MULU 0x1234 × 0x0100 → `busy` high T+1..T+16; T+17: `done`, result 0x3400, resultHigh 0x0012, overflow 1. A `start` of ADD at T+5 is ignored.
4. DIVU 100 / 7 → T+17: result 0x000E, resultHigh 0x0002, overflow 0. DIVU 0x1234 / 0 → T+1: result 0xFFFF, resultHigh 0x1234, overflow 1, `busy` never asserted.
5. `resetN` low at T+5 during MULU → all outputs 0 immediately, no `done` pulse. After release, ADD 2 + 3 gives result 0x0005 at the following T+1.
6. SWAP 0xAB12 → 0x12AB. LDHI op1=0xAB12, op2=0x0034 → 0xAB34. Illegal SHIFT opcode 6 with op1=0x5555 → result 0x5555, carry = carryIn, single cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation class and opcode
// encodings, sequencer states, and the signed-overflow helper.
package alu_pkg;

  // Operation classes
  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_SHIFT  = 2'd1;
  localparam logic [1:0] CLS_LOAD   = 2'd2;
  localparam logic [1:0] CLS_MULDIV = 2'd3;

  // ALU class opcodes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  // SHIFT class opcodes (5..7 illegal)
  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_ASHR = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  // LOAD class opcodes
  localparam logic [2:0] OP_COPY  = 3'd0;
  localparam logic [2:0] OP_LDL   = 3'd1;
  localparam logic [2:0] OP_LDH   = 3'd2;
  localparam logic [2:0] OP_SWAP  = 3'd3;
  localparam logic [2:0] OP_LDLI  = 3'd4;
  localparam logic [2:0] OP_LDHI  = 3'd5;
  localparam logic [2:0] OP_LDLZI = 3'd6;
  localparam logic [2:0] OP_LDHZI = 3'd7;

  // MULDIV class opcodes (2..7 illegal)
  localparam logic [2:0] OP_MULU = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  // Two's-complement overflow from operand/result sign bits; for a subtract
  // the second operand's sign is inverted before the same-sign test.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: ALU, SHIFT and LOAD classes.
// Anything not decoded here (illegal opcodes, MULDIV class) falls through to
// the illegal-op behaviour: result = operand1, carry passes, no overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       opClass,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             carryIn,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow
);

  localparam int H = WIDTH / 2;

  logic [WIDTH:0] ext;

  // Decode class/opcode into result, carry and signed overflow
  always_comb begin
    result   = operand1;
    carryOut = carryIn;
    overflow = 1'b0;
    ext      = '0;
    case (opClass)
      CLS_ALU: begin
        case (operation)
          OP_ADD, OP_ADC: begin
            ext = {1'b0, operand1} + {1'b0, operand2}
                + {{WIDTH{1'b0}}, (operation == OP_ADC) & carryIn};
            result   = ext[WIDTH-1:0];
            carryOut = ext[WIDTH];
            overflow = signed_ovf(operand1[WIDTH-1], operand2[WIDTH-1],
                                  ext[WIDTH-1], 1'b0);
          end
          OP_SUB, OP_SBC: begin
            ext = {1'b0, operand1} - {1'b0, operand2}
                - {{WIDTH{1'b0}}, (operation == OP_SBC) & carryIn};
            result   = ext[WIDTH-1:0];
            carryOut = ext[WIDTH];
            overflow = signed_ovf(operand1[WIDTH-1], operand2[WIDTH-1],
                                  ext[WIDTH-1], 1'b1);
          end
          OP_AND:  result = operand1 & operand2;
          OP_OR:   result = operand1 | operand2;
          OP_XOR:  result = operand1 ^ operand2;
          default: result = ~operand1;
        endcase
      end
      CLS_SHIFT: begin
        case (operation)
          OP_SHR: begin
            result   = {1'b0, operand1[WIDTH-1:1]};
            carryOut = operand1[0];
          end
          OP_SHL: begin
            result   = {operand1[WIDTH-2:0], 1'b0};
            carryOut = operand1[WIDTH-1];
          end
          OP_ASHR: begin
            result   = {operand1[WIDTH-1], operand1[WIDTH-1:1]};
            carryOut = operand1[0];
          end
          OP_ROR: begin
            result   = {carryIn, operand1[WIDTH-1:1]};
            carryOut = operand1[0];
          end
          OP_ROL: begin
            result   = {operand1[WIDTH-2:0], carryIn};
            carryOut = operand1[WIDTH-1];
          end
          default: ;
        endcase
      end
      CLS_LOAD: begin
        case (operation)
          OP_COPY:  result = operand1;
          OP_LDL:   result = {{H{1'b0}}, operand1[H-1:0]};
          OP_LDH:   result = {{H{1'b0}}, operand1[WIDTH-1:H]};
          OP_SWAP:  result = {operand1[H-1:0], operand1[WIDTH-1:H]};
          OP_LDLI:  result = {operand2[WIDTH-1:H], operand1[H-1:0]};
          OP_LDHI:  result = {operand1[WIDTH-1:H], operand2[H-1:0]};
          OP_LDLZI: result = {{H{1'b0}}, operand1[H-1:0]};
          default:  result = {operand1[WIDTH-1:H], {H{1'b0}}};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with iterative unsigned multiply/divide and a
// start/busy/done handshake. Single-cycle ops complete the cycle after
// acceptance; MULU/DIVU iterate one bit per cycle for WIDTH cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       opClass,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHigh,
  output logic             carryOut,
  output logic             zeroOut,
  output logic             negativeOut,
  output logic             overflowOut
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam bit MD = (MULDIV_EN != 0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;      // multiplicand / divisor
  logic [WIDTH-1:0] b_q, b_d;      // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] acc_q, acc_d;  // product high / partial remainder
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] core_res;
  logic             core_c, core_v;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] mul_add;
  logic             q_bit;
  logic             is_mulu, is_divu;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .opClass   (opClass),
    .operation (operation),
    .operand1  (operand1),
    .operand2  (operand2),
    .carryIn   (carryIn),
    .result    (core_res),
    .carryOut  (core_c),
    .overflow  (core_v)
  );

  assign is_mulu = MD && (opClass == CLS_MULDIV) && (operation == OP_MULU);
  assign is_divu = MD && (opClass == CLS_MULDIV) && (operation == OP_DIVU);

  // Sequencer next state, iteration datapath and output/flag updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cin_d     = cin_q;
    res_d     = res_q;
    hi_d      = hi_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    done_d    = 1'b0;
    mul_sum   = '0;
    mul_add   = '0;
    div_shift = '0;
    div_diff  = '0;
    q_bit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mulu) begin
            state_d = MUL;
            cnt_d   = '0;
            a_d     = operand1;
            b_d     = operand2;
            acc_d   = '0;
            cin_d   = carryIn;
          end else if (is_divu && (operand2 != '0)) begin
            state_d = DIV;
            cnt_d   = '0;
            a_d     = operand2;
            b_d     = operand1;
            acc_d   = '0;
            cin_d   = carryIn;
          end else if (is_divu) begin
            done_d = 1'b1;
            res_d  = '1;
            hi_d   = operand1;
            c_d    = carryIn;
            z_d    = 1'b0;
            n_d    = 1'b1;
            v_d    = 1'b1;
          end else begin
            done_d = 1'b1;
            res_d  = core_res;
            hi_d   = '0;
            c_d    = core_c;
            z_d    = (core_res == '0);
            n_d    = core_res[WIDTH-1];
            v_d    = core_v;
          end
        end
      end
      MUL: begin
        // Shift-add: add multiplicand into the high word, then shift the
        // {high, multiplier} pair right so the product fills in from the top.
        mul_add = b_q[0] ? a_q : '0;
        mul_sum = {1'b0, acc_q} + {1'b0, mul_add};
        acc_d   = mul_sum[WIDTH:1];
        b_d     = {mul_sum[0], b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_d == CW'(WIDTH)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = b_d;
          hi_d    = acc_d;
          c_d     = cin_q;
          z_d     = ({acc_d, b_d} == '0);
          n_d     = acc_d[WIDTH-1];
          v_d     = (acc_d != '0);
        end
      end
      DIV: begin
        // Restoring step: the partial remainder stays below the divisor, so
        // the borrow bit of the WIDTH+1 subtraction is a reliable sign.
        div_shift = {acc_q, b_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_q};
        q_bit     = ~div_diff[WIDTH];
        acc_d     = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        b_d       = {b_q[WIDTH-2:0], q_bit};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_d == CW'(WIDTH)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = b_d;
          hi_d    = acc_d;
          c_d     = cin_q;
          z_d     = (b_d == '0);
          n_d     = b_d[WIDTH-1];
          v_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and registered outputs; reset aborts any op
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = res_q;
  assign resultHigh  = hi_q;
  assign carryOut    = c_q;
  assign zeroOut     = z_q;
  assign negativeOut = n_q;
  assign overflowOut = v_q;

endmodule
